// File: rtl/canvas_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : canvas_sampler
//  Purpose  : Quantises cursor paint/erase requests into a GRID_W x GRID_H
//             cell bitmap (sequential subtract-and-count divider) and
//             streams the bitmap row-major, one bit per beat, over a
//             valid/ready handshake.
//  Options  : CANVAS_THICK_EN - when defined, each write also updates the
//             four in-grid neighbours of the target cell.
//  Revision : 1.0 - initial release
// ============================================================================
module canvas_sampler #(
    parameter int X0     = 88,
    parameter int Y0     = 37,
    parameter int CELL_W = 10,
    parameter int CELL_H = 14,
    parameter int GRID_W = 14,
    parameter int GRID_H = 14,
    parameter int IDX_W  = 8
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             paint_valid,
    output logic             paint_ready,
    input  logic [8:0]       paint_x,
    input  logic [8:0]       paint_y,
    input  logic             paint_erase,
    input  logic             clear,
    input  logic             start,
    output logic             px_valid,
    input  logic             px_ready,
    output logic             px_data,
    output logic [IDX_W-1:0] px_index,
    output logic             px_last,
    output logic             done
);

    localparam int c_cells = GRID_W * GRID_H;
    localparam int c_col_w = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int c_row_w = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int c_x_hi  = X0 + GRID_W * CELL_W;
    localparam int c_y_hi  = Y0 + GRID_H * CELL_H;

    localparam logic [8:0]       c_x0       = 9'(X0);
    localparam logic [8:0]       c_y0       = 9'(Y0);
    localparam logic [8:0]       c_cell_w   = 9'(CELL_W);
    localparam logic [8:0]       c_cell_h   = 9'(CELL_H);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(c_cells - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_WRITE  = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [8:0]         r_rx;
    logic [8:0]         r_ry;
    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic               r_erase;
    logic [c_cells-1:0] r_bits;
    logic [c_cells-1:0] w_bits_next;
    logic [c_cells-1:0] w_hit;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;

    logic w_in_range;
    logic w_accept;
    logic w_rx_ge;
    logic w_ry_ge;
    logic w_beat;
    logic w_beat_last;
    logic w_idle_clear;
    logic w_idle_start;

    // Range check is purely combinational on the request so out-of-range
    // requests can be consumed and dropped in the same cycle.
    assign w_in_range = (int'(paint_x) >= X0) && (int'(paint_x) < c_x_hi) &&
                        (int'(paint_y) >= Y0) && (int'(paint_y) < c_y_hi);

    assign w_idle_clear = (r_state == ST_IDLE) && clear;
    assign w_idle_start = (r_state == ST_IDLE) && !clear && start;
    assign w_accept     = paint_ready && paint_valid && w_in_range;

    assign w_rx_ge = (r_rx >= c_cell_w);
    assign w_ry_ge = (r_ry >= c_cell_h);

    assign w_beat      = (r_state == ST_STREAM) && px_ready;
    assign w_beat_last = w_beat && (r_idx == c_last_idx);

    assign px_index = r_idx;
    assign done     = r_done;

    // Cell-select decode: one hit line per bitmap cell for the WRITE cycle.
    for (genvar gr = 0; gr < GRID_H; gr++) begin : g_row
        for (genvar gc = 0; gc < GRID_W; gc++) begin : g_col
            logic w_self;
            assign w_self = (int'(r_row) == gr) && (int'(r_col) == gc);
`ifdef CANVAS_THICK_EN
            // A cell is a neighbour when the target sits one step away;
            // cells outside the grid simply do not exist, so no wrap occurs.
            logic w_near;
            assign w_near = ((int'(r_row) == gr) &&
                             ((int'(r_col) == gc - 1) || (int'(r_col) == gc + 1))) ||
                            ((int'(r_col) == gc) &&
                             ((int'(r_row) == gr - 1) || (int'(r_row) == gr + 1)));
            assign w_hit[gr*GRID_W+gc] = w_self || w_near;
`else
            assign w_hit[gr*GRID_W+gc] = w_self;
`endif
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; IDLE priority is clear > start > paint.
    always_comb begin
        w_state_next = r_state;
        paint_ready  = 1'b0;
        px_valid     = 1'b0;
        px_data      = 1'b0;
        px_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                paint_ready = !clear && !start;
                if (clear) begin
                    w_state_next = ST_IDLE;
                end else if (start) begin
                    w_state_next = ST_STREAM;
                end else if (paint_valid && w_in_range) begin
                    w_state_next = ST_DIV;
                end
            end
            ST_DIV: begin
                if (!w_rx_ge && !w_ry_ge) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_next = ST_IDLE;
            end
            ST_STREAM: begin
                px_valid = 1'b1;
                px_data  = r_bits[r_idx];
                px_last  = (r_idx == c_last_idx);
                if (w_beat_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Divider datapath: latch offsets on accept, then subtract-and-count.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_rx    <= '0;
            r_ry    <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_erase <= 1'b0;
        end else if (w_accept) begin
            r_rx    <= paint_x - c_x0;
            r_ry    <= paint_y - c_y0;
            r_col   <= '0;
            r_row   <= '0;
            r_erase <= paint_erase;
        end else if (r_state == ST_DIV) begin
            if (w_rx_ge) begin
                r_rx  <= r_rx - c_cell_w;
                r_col <= r_col + c_col_w'(1);
            end
            if (w_ry_ge) begin
                r_ry  <= r_ry - c_cell_h;
                r_row <= r_row + c_row_w'(1);
            end
        end
    end

    // Bitmap update: whole-map clear in IDLE, masked write in WRITE.
    always_comb begin
        w_bits_next = r_bits;
        if (w_idle_clear) begin
            w_bits_next = '0;
        end else if (r_state == ST_WRITE) begin
            w_bits_next = (r_bits & ~w_hit) | (w_hit & {c_cells{~r_erase}});
        end
    end

    // Bitmap storage.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_bits <= '0;
        end else begin
            r_bits <= w_bits_next;
        end
    end

    // Stream index and the one-cycle done pulse after the final beat.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_beat_last;
            if (w_idle_start) begin
                r_idx <= '0;
            end else if (w_beat) begin
                r_idx <= w_beat_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_canvas_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_canvas_sampler
//  Purpose  : Self-checking bench for canvas_sampler: table of paint
//             requests with hand-computed cell index and busy length,
//             each followed by a full stream compared against a bitmap
//             model; plus hand sequences for handshake stalls, ignored
//             pulses, clear-versus-paint and reset mid-stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_canvas_sampler;

    localparam int N  = 196;
    localparam int GW = 14;
    localparam int GH = 14;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       paint_valid;
    logic       paint_ready;
    logic [8:0] paint_x;
    logic [8:0] paint_y;
    logic       paint_erase;
    logic       clear;
    logic       start;
    logic       px_valid;
    logic       px_ready;
    logic       px_data;
    logic [7:0] px_index;
    logic       px_last;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit model [N];

    typedef struct {
        int    x;
        int    y;
        bit    erase;
        int    low;   // cycles paint_ready stays low after accept
        int    idx;   // target cell, -1 when the request is dropped
        string name;
    } vec_t;

    vec_t vecs [7];

    always #5 CLOCK_50 = ~CLOCK_50;

    canvas_sampler dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .paint_valid (paint_valid),
        .paint_ready (paint_ready),
        .paint_x     (paint_x),
        .paint_y     (paint_y),
        .paint_erase (paint_erase),
        .clear       (clear),
        .start       (start),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_data     (px_data),
        .px_index    (px_index),
        .px_last     (px_last),
        .done        (done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void set_cell(input int r, input int c, input bit v);
        if (r >= 0 && r < GH && c >= 0 && c < GW) model[r*GW+c] = v;
    endfunction

    function automatic void model_write(input int idx, input bit v);
        int r;
        int c;
        r = idx / GW;
        c = idx % GW;
        set_cell(r, c, v);
`ifdef CANVAS_THICK_EN
        set_cell(r - 1, c, v);
        set_cell(r + 1, c, v);
        set_cell(r, c - 1, v);
        set_cell(r, c + 1, v);
`endif
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) model[i] = 1'b0;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_paint(input int x, input int y, input bit e,
                            input int low_exp, input string nm);
        int low;
        bit back;
        paint_x     = 9'(x);
        paint_y     = 9'(y);
        paint_erase = e;
        paint_valid = 1'b1;
        @(negedge CLOCK_50);
        chk({nm, "_ready_at_req"}, int'(paint_ready), 1);
        @(posedge CLOCK_50);
        #1 paint_valid = 1'b0;
        low  = 0;
        back = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (paint_ready) begin
                back = 1'b1;
                break;
            end
            low++;
            @(posedge CLOCK_50);
            #1;
        end
        chk({nm, "_busy_cycles"}, low, low_exp);
        if (back) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Full stream compared beat by beat against the model.
    task automatic run_stream(input bit toggle, input bit inject, input string nm);
        int k;
        int cyc;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 2000) begin
            px_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (inject) begin
                start = (cyc == 5);
                clear = (cyc == 9);
            end
            @(negedge CLOCK_50);
            chk($sformatf("%s_valid[%0d]", nm, k), int'(px_valid), 1);
            chk($sformatf("%s_index[%0d]", nm, k), int'(px_index), k);
            chk($sformatf("%s_data[%0d]", nm, k), int'(px_data), int'(model[k]));
            chk($sformatf("%s_last[%0d]", nm, k), int'(px_last), (k == N - 1) ? 1 : 0);
            @(posedge CLOCK_50);
            if (px_ready) k++;
            #1;
            cyc++;
        end
        start = 1'b0;
        clear = 1'b0;
        chk({nm, "_beats_done"}, k, N);
        @(negedge CLOCK_50);
        chk({nm, "_done_pulse"}, int'(done), 1);
        chk({nm, "_valid_after"}, int'(px_valid), 0);
        chk({nm, "_index_after"}, int'(px_index), 0);
        @(posedge CLOCK_50);
        #1;
        @(negedge CLOCK_50);
        chk({nm, "_done_single"}, int'(done), 0);
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;

        //            x    y    e  low  idx  name
        vecs[0] = '{ 88,  37, 1'b0,  2,   0, "p88_37"};
        vecs[1] = '{217, 219, 1'b0, 15, 194, "p217_219"};
        vecs[2] = '{150, 100, 1'b0,  8,  62, "p150_100"};
        vecs[3] = '{217, 219, 1'b1, 15, 194, "e217_219"};
        vecs[4] = '{ 87, 100, 1'b0,  0,  -1, "drop_x_low"};
        vecs[5] = '{100, 233, 1'b0,  0,  -1, "drop_y_high"};
        vecs[6] = '{227, 232, 1'b0, 15, 195, "p227_232"};

        resetn      = 1'b0;
        paint_valid = 1'b0;
        paint_x     = '0;
        paint_y     = '0;
        paint_erase = 1'b0;
        clear       = 1'b0;
        start       = 1'b0;
        px_ready    = 1'b0;
        model_clear();

        repeat (3) @(posedge CLOCK_50);
        #1 resetn = 1'b1;
        @(negedge CLOCK_50);
        chk("rst_paint_ready", int'(paint_ready), 1);
        chk("rst_px_valid", int'(px_valid), 0);
        chk("rst_px_data", int'(px_data), 0);
        chk("rst_px_last", int'(px_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_px_index", int'(px_index), 0);
        @(posedge CLOCK_50);
        #1;

        run_stream(1'b0, 1'b0, "s_reset");

        for (int v = 0; v < 7; v++) begin
            do_paint(vecs[v].x, vecs[v].y, vecs[v].erase, vecs[v].low, vecs[v].name);
            if (vecs[v].idx >= 0) model_write(vecs[v].idx, ~vecs[v].erase);
            run_stream(1'b0, 1'b0, {"s_", vecs[v].name});
        end

        // Stalled stream with start/clear pulses that must be ignored.
        run_stream(1'b1, 1'b1, "s_toggle");
        run_stream(1'b0, 1'b0, "s_after_toggle");

        // clear wins over a simultaneous paint request.
        paint_x     = 9'd88;
        paint_y     = 9'd37;
        paint_erase = 1'b0;
        paint_valid = 1'b1;
        clear       = 1'b1;
        @(negedge CLOCK_50);
        chk("clr_paint_ready", int'(paint_ready), 0);
        @(posedge CLOCK_50);
        #1;
        paint_valid = 1'b0;
        clear       = 1'b0;
        @(negedge CLOCK_50);
        chk("clr_no_div", int'(paint_ready), 1);
        @(posedge CLOCK_50);
        #1;
        model_clear();
        run_stream(1'b0, 1'b0, "s_cleared");

        // Reset asserted mid-stream at index 50.
        do_paint(88, 37, 1'b0, 2, "repaint");
        model_write(0, 1'b1);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        px_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLOCK_50);
            if (px_index == 8'd50) begin
                found = 1'b1;
                break;
            end
            @(posedge CLOCK_50);
            #1;
        end
        chk("mid_reach_idx50", int'(found), 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_px_valid", int'(px_valid), 0);
        chk("mid_rst_px_index", int'(px_index), 0);
        chk("mid_rst_px_data", int'(px_data), 0);
        @(posedge CLOCK_50);
        #1 resetn = 1'b1;
        model_clear();
        run_stream(1'b0, 1'b0, "s_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
